display_scan_ctrl: RTL

Time-multiplexed scan controller that shares one `units_decoder` instance across NUM_DIGITS common-anode seven-segment digits. It accepts a packed BCD value over a valid/ready handshake and double-buffers it so that a new value takes effect only at a frame boundary. Each cycle it presents one nibble to the decoder and registers the decoder's active-low segments. It drives active-low anode selects, with guard gaps between digits to prevent ghosting.

---
 rtl/display_scan_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
`timescale 1ns/1ps
// display_scan_ctrl: time-multiplexed seven-segment scan controller.
// One external decoder is shared across all digits. A packed BCD value is
// double-buffered (staging -> shadow) so new content only lands on a frame
// boundary. Anodes are active-low with an all-off guard gap before each digit.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int ON_CYCLES    = 1000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    lz_en,
  output logic [3:0]              digit_code,
  input  logic [7:0]              seg_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int MAXC = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int IW   = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_GUARD = 2'd1, ST_SHOW = 2'd2} state_t;

  state_t                  r_state, w_state_nxt;
  logic [IW-1:0]           r_idx, w_idx_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;

  logic [4*NUM_DIGITS-1:0] r_stg_data, r_sh_data;
  logic [NUM_DIGITS-1:0]   r_stg_blank, r_sh_blank;
  logic [NUM_DIGITS-1:0]   r_stg_dp, r_sh_dp;
  logic                    r_pending;
  logic [7:0]              r_seg;
  logic                    r_frame_done;

  logic                    w_show_last, w_boundary, w_apply;
  logic [3:0]              w_nib;
  logic                    w_blk, w_dpi, w_zero_up, w_blank;
  logic [NUM_DIGITS-1:0]   w_an;
  logic                    w_unused;

  // Decoder bit 7 carries nothing useful; dp comes from the shadow mask.
  assign w_unused    = seg_in[7];

  assign w_show_last = (r_state == ST_SHOW) && (r_cnt == CW'(ON_CYCLES - 1));
  assign w_boundary  = enable && w_show_last && (r_idx == IW'(NUM_DIGITS - 1));
  // Staging moves to shadow at a frame boundary, or immediately while idle.
  assign w_apply     = r_pending && (w_boundary || (r_state == ST_OFF));

  // Scan state, digit index and cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: OFF -> GUARD -> SHOW -> GUARD ...; enable low forces OFF.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    if (!enable) begin
      w_state_nxt = ST_OFF;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_GUARD;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
        ST_GUARD: begin
          if (r_cnt == CW'(GUARD_CYCLES - 1)) begin
            w_state_nxt = ST_SHOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (w_show_last) begin
            w_state_nxt = ST_GUARD;
            w_cnt_nxt   = '0;
            w_idx_nxt   = (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Staging capture on handshake; pending clears when shadow takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_data  <= '0;
      r_stg_blank <= '0;
      r_stg_dp    <= '0;
      r_pending   <= 1'b0;
    end else if (load_valid && !r_pending) begin
      r_stg_data  <= load_data;
      r_stg_blank <= load_blank;
      r_stg_dp    <= load_dp;
      r_pending   <= 1'b1;
    end else if (w_apply) begin
      r_pending   <= 1'b0;
    end
  end

  // Shadow copy that the scan actually displays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_data  <= '0;
      r_sh_blank <= '0;
      r_sh_dp    <= '0;
    end else if (w_apply) begin
      r_sh_data  <= r_stg_data;
      r_sh_blank <= r_stg_blank;
      r_sh_dp    <= r_stg_dp;
    end
  end

  // Select current digit fields and test whether it and all above are zero.
  always_comb begin
    logic v_run;
    w_nib     = '0;
    w_blk     = 1'b0;
    w_dpi     = 1'b0;
    w_zero_up = 1'b0;
    v_run     = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_run = v_run && (r_sh_data[4*i +: 4] == 4'd0);
      if (r_idx == IW'(i)) begin
        w_nib     = r_sh_data[4*i +: 4];
        w_blk     = r_sh_blank[i];
        w_dpi     = r_sh_dp[i];
        w_zero_up = v_run;
      end
    end
  end

  assign w_blank = w_blk || (lz_en && (r_idx != '0) && w_zero_up);

  // Segment register: blank when idle or when the digit is suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_seg <= 8'hFF;
    else if (!enable || (r_state == ST_OFF) || w_blank)
      r_seg <= 8'hFF;
    else
      r_seg <= {~w_dpi, seg_in[6:0]};
  end

  // Frame pulse for the cycle following the last SHOW of the top digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_done <= 1'b0;
    else        r_frame_done <= w_boundary;
  end

  // Anode decode straight from registered state; only SHOW drives one low.
  always_comb begin
    w_an = '1;
    if (r_state == ST_SHOW) w_an[r_idx] = 1'b0;
  end

  assign an_n       = w_an;
  assign digit_code = (r_state == ST_OFF) ? 4'd0 : w_nib;
  assign seg_out    = r_seg;
  assign load_ready = !r_pending;
  assign frame_done = r_frame_done;

endmodule
